// File: rtl/norm_shifter_pkg.sv
// Shared CPU datapath package: FSM state encoding, datapath width and the
// normalisation stop rule used by the iterative normaliser.
package norm_shifter_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MAX_SHIFT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    // Normalised once the top bit is set (unsigned) or the top two bits differ (signed).
    function automatic logic norm_top_ok(input logic msb, input logic next_msb, input logic smode);
        return smode ? (msb ^ next_msb) : msb;
    endfunction

endpackage

// File: rtl/norm_shifter.sv
// Iterative one-bit-per-cycle normaliser: reports the left-shift count that
// normalises a signed or unsigned operand together with the shifted value.
module norm_shifter
    import norm_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] in,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    localparam int unsigned CW      = $clog2(WIDTH);
    localparam int unsigned CAP     = WIDTH - 1;

    norm_state_t      state;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    count;
    logic             mode;

    logic             accept_c;
    logic             load_stop_c;
    logic             run_stop_c;

    // Accept qualifier and stop detect for both the incoming operand and the working register.
    always_comb begin
        accept_c    = start & in_ready;
        load_stop_c = norm_top_ok(in[WIDTH-1], in[WIDTH-2], signed_mode);
        run_stop_c  = (count == CW'(CAP)) | norm_top_ok(data[WIDTH-1], data[WIDTH-2], mode);
    end

    // Control FSM, working register and registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            data      <= '0;
            count     <= '0;
            mode      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            cnt       <= '0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept_c) begin
                        data      <= in;
                        mode      <= signed_mode;
                        count     <= '0;
                        zero      <= (in == '0);
                        out_valid <= 1'b0;
                        in_ready  <= load_stop_c;
                        state     <= load_stop_c ? DONE : SHIFT;
                    end else if (state == DONE) begin
                        // Immediate-stop operands publish their result one cycle after accept.
                        out_valid <= 1'b1;
                        out       <= data;
                        cnt       <= CNT_W'(count);
                    end
                end
                SHIFT: begin
                    if (run_stop_c) begin
                        state     <= DONE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b1;
                        out       <= data;
                        cnt       <= CNT_W'(count);
                    end else begin
                        data  <= {data[WIDTH-2:0], 1'b0};
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_norm_shifter.sv
// Scoreboard bench for norm_shifter: directed corner cases plus random operands
// checked against a leading-bit-count reference model.
module tb_norm_shifter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] din;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] dout;
    logic [15:0] cnt;
    logic        zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] op;
        logic        sm;
        logic [15:0] out;
        logic [15:0] cnt;
        logic        zero;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    norm_shifter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .signed_mode(signed_mode),
        .in         (din),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out        (dout),
        .cnt        (cnt),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: count leading sign/zero bits, capped at 15.
    function automatic int model_cnt(input logic [15:0] v, input logic sm);
        int hi = -1;
        int n;
        if (sm) begin
            for (int i = 0; i < 15; i++) if (v[i] != v[15]) hi = i;
            n = 14 - hi;
        end else begin
            for (int i = 0; i < 16; i++) if (v[i]) hi = i;
            n = 15 - hi;
        end
        return (n > 15) ? 15 : n;
    endfunction

    // Monitor: each rising out_valid is matched against the oldest expectation.
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        if (reset_n && out_valid && !ov_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(dout), 32'hDEAD);
            end else begin
                exp_t e;
                logic [15:0] shifted;
                e = exp_q.pop_front();
                chk("out", 32'(dout), 32'(e.out));
                chk("cnt", 32'(cnt), 32'(e.cnt));
                chk("zero", 32'(zero), 32'(e.zero));
                chk("latency", 32'(cyc), 32'(e.due));
                shifted = e.op << cnt;
                chk("out_eq_in_shl_cnt", 32'(dout), 32'(shifted));
                if (e.sm) chk("sign_kept", 32'(dout[15]), 32'(e.op[15]));
            end
        end
        ov_prev <= reset_n ? out_valid : 1'b0;
    end

    // Drive one accept and push its expected result.
    task automatic accept(input logic [15:0] v, input logic sm);
        exp_t e;
        int   n;
        int   guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        n           = model_cnt(v, sm);
        start       = 1'b1;
        din         = v;
        signed_mode = sm;
        e.op   = v;
        e.sm   = sm;
        e.cnt  = 16'(n);
        e.out  = v << n;
        e.zero = (v == 16'h0000);
        e.due  = cyc + 1 + n + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        din         = 16'($urandom);
        signed_mode = 1'($urandom);
        chk("valid_cleared_on_accept", 32'(out_valid), 32'd0);
        chk("in_ready_after_accept", 32'(in_ready), (n == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] v, input logic sm);
        accept(v, sm);
        wait_done();
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        din         = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(dout), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;

        // Directed corner cases.
        run_op(16'h0001, 1'b0);
        run_op(16'h0003, 1'b1);
        run_op(16'hFFF0, 1'b1);
        run_op(16'h4000, 1'b1);
        run_op(16'h0000, 1'b1);
        run_op(16'h0000, 1'b0);
        run_op(16'hFFFF, 1'b1);
        run_op(16'h8000, 1'b0);

        // Start during SHIFT must be ignored.
        accept(16'h0010, 1'b0);
        @(negedge clk);
        start = 1'b1;
        din   = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_ready", 32'(in_ready), 32'd0);
        wait_done();

        // Back-to-back accept from DONE drops out_valid on that edge.
        accept(16'h0100, 1'b1);
        wait_done();

        // Async reset mid-SHIFT aborts with no result.
        accept(16'h0001, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_cnt", 32'(cnt), 32'd0);
        chk("abort_out", 32'(dout), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_result", 32'(out_valid), 32'd0);
        run_op(16'h0C00, 1'b0);

        // Random operands, random gaps, sometimes back-to-back.
        for (int k = 0; k < 60; k++) begin
            logic [15:0] v;
            logic        sm;
            v  = 16'($urandom) >> $urandom_range(0, 15);
            sm = 1'($urandom);
            if (sm && $urandom_range(0, 1) == 1) v = ~v;
            run_op(v, sm);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
